// File: rtl/cam_mem_pkg.sv
// Shared constants for the data-side memory responder: memory map, register bits, capture states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_mem_pkg;

   // Default region sizes in 32-bit words
   localparam int unsigned DEF_DATA_WORDS = 1024;
   localparam int unsigned DEF_FB_WORDS   = 4800;   // 160x120 8-bit pixels, four per word

   // Region base byte addresses
   localparam logic [31:0] DATA_BASE = 32'h0000_0000;
   localparam logic [31:0] FB_BASE   = 32'h0001_0000;
   localparam logic [31:0] REG_BASE  = 32'h0002_0000;

   // Register byte offsets from REG_BASE
   localparam logic [31:0] CTRL_OFF   = 32'h0000_0000;
   localparam logic [31:0] STATUS_OFF = 32'h0000_0004;
   localparam logic [31:0] PIXCNT_OFF = 32'h0000_0008;

   // CTRL bits
   localparam int CTRL_CAP_EN = 0;
   localparam int CTRL_CLEAR  = 1;

   // STATUS bits
   localparam int ST_FRAME_DONE = 0;
   localparam int ST_BUSY       = 1;
   localparam int ST_RESYNC     = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      CAPTURE  = 2'd2,
      DONE     = 2'd3
   } capture_state_t;

endpackage

// File: rtl/camera_capture.sv
// Camera capture engine: packs 8-bit pixels into 32-bit words and emits frame-buffer writes.
// Latency: packed word written on the same edge as its 4th pixel; flags update on that edge.
// Backpressure: none; pixels arriving outside CAPTURE are dropped.
//
// Ports: clk/reset (async active-low); cap_en/clear are the effective CTRL values for this edge;
// pix_valid/pix_data/frame_start from the sensor; fb_we/fb_waddr/fb_wdata write port into the
// frame buffer; frame_done/resync/busy/pixcnt feed STATUS and PIXCNT.
module camera_capture
   import cam_mem_pkg::*;
#(
   parameter int unsigned FB_WORDS = DEF_FB_WORDS,
   parameter int unsigned FA_W     = $clog2(FB_WORDS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cap_en,
   input  logic            clear,
   input  logic            pix_valid,
   input  logic [7:0]      pix_data,
   input  logic            frame_start,
   output logic            fb_we,
   output logic [FA_W-1:0] fb_waddr,
   output logic [31:0]     fb_wdata,
   output logic            frame_done,
   output logic            resync,
   output logic            busy,
   output logic [15:0]     pixcnt
);

   capture_state_t state, state_nxt;
   logic [1:0]  lane, lane_nxt, lane_eff;
   logic [23:0] pack, pack_nxt;
   logic [15:0] idx, idx_nxt, idx_eff;
   logic        done_nxt, resync_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         lane       <= 2'd0;
         pack       <= 24'd0;
         idx        <= 16'd0;
         frame_done <= 1'b0;
         resync     <= 1'b0;
      end else begin
         state      <= state_nxt;
         lane       <= lane_nxt;
         pack       <= pack_nxt;
         idx        <= idx_nxt;
         frame_done <= done_nxt;
         resync     <= resync_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      lane_nxt   = lane;
      pack_nxt   = pack;
      idx_nxt    = idx;
      done_nxt   = frame_done;
      resync_nxt = resync;
      lane_eff   = lane;
      idx_eff    = idx;
      fb_we      = 1'b0;

      if (clear) begin
         done_nxt   = 1'b0;
         resync_nxt = 1'b0;
      end

      if (!cap_en) begin
         // Disabling drops any partial word but keeps frame_done for software.
         state_nxt = IDLE;
         lane_nxt  = 2'd0;
      end else if (clear && state == DONE) begin
         state_nxt = WAIT_SOF;
      end else begin
         case (state)
            IDLE: state_nxt = WAIT_SOF;
            WAIT_SOF: begin
               if (frame_start) begin
                  state_nxt = CAPTURE;
                  lane_nxt  = 2'd0;
                  idx_nxt   = 16'd0;
               end
            end
            CAPTURE: begin
               // A mid-frame start restarts first, so a coincident pixel lands as pixel 0.
               if (frame_start) begin
                  lane_eff   = 2'd0;
                  idx_eff    = 16'd0;
                  lane_nxt   = 2'd0;
                  idx_nxt    = 16'd0;
                  resync_nxt = 1'b1;
               end
               if (pix_valid) begin
                  if (lane_eff == 2'd3) begin
                     fb_we    = 1'b1;
                     lane_nxt = 2'd0;
                     idx_nxt  = idx_eff + 16'd1;
                     if (idx_eff == 16'(FB_WORDS - 1)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                     end
                  end else begin
                     lane_nxt = lane_eff + 2'd1;
                     case (lane_eff)
                        2'd0:    pack_nxt[7:0]   = pix_data;
                        2'd1:    pack_nxt[15:8]  = pix_data;
                        default: pack_nxt[23:16] = pix_data;
                     endcase
                  end
               end
            end
            default: ;  // DONE holds until clear or disable
         endcase
      end
   end

   assign fb_waddr = idx_eff[FA_W-1:0];
   assign fb_wdata = {pix_data, pack};
   assign busy     = (state == WAIT_SOF) || (state == CAPTURE);
   assign pixcnt   = idx;

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: data RAM, read-only frame buffer, CTRL/STATUS/PIXCNT registers.
// Latency: loads answer one cycle after the request; stores commit on the request edge.
// Backpressure: none; one access per cycle is always accepted, errors are pulsed on mem_err.
//
// Ports: clk/reset (async active-low); mem_req/mem_we/mem_addr/mem_wdata core request;
// mem_rdata/mem_rvalid/mem_err response; pix_valid/pix_data/frame_start camera; frame_irq level.
module data_mem_responder
   import cam_mem_pkg::*;
#(
   parameter int unsigned DATA_WORDS = DEF_DATA_WORDS,
   parameter int unsigned FB_WORDS   = DEF_FB_WORDS,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_rvalid,
   output logic              mem_err,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   input  logic              frame_start,
   output logic              frame_irq
);

   localparam int unsigned DA_W = $clog2(DATA_WORDS);
   localparam int unsigned FA_W = $clog2(FB_WORDS);

   logic [31:0] dram [DATA_WORDS];
   logic [31:0] fbuf [FB_WORDS];

   logic [ADDR_W-1:0] waddr, fb_off;
   logic hit_data, hit_fb, hit_ctrl, hit_status, hit_pixcnt, mapped, writable;
   logic ld, st, ctrl_wr, cap_en, cap_en_in, clear;
   logic [31:0] rd_mux;

   logic            fb_we, frame_done, resync, busy;
   logic [FA_W-1:0] fb_waddr;
   logic [31:0]     fb_wdata;
   logic [15:0]     pixcnt;
   logic            unused_addr_bits;

   // Word-aligned address; the low two bits never select anything.
   assign waddr  = {mem_addr[ADDR_W-1:2], 2'b00};
   assign fb_off = waddr - ADDR_W'(FB_BASE);
   assign unused_addr_bits = ^{mem_addr[1:0], fb_off[ADDR_W-1:FA_W+2], fb_off[1:0]};

   assign hit_data   = waddr < ADDR_W'(DATA_BASE + 32'(4 * DATA_WORDS));
   assign hit_fb     = (waddr >= ADDR_W'(FB_BASE)) && (waddr < ADDR_W'(FB_BASE + 32'(4 * FB_WORDS)));
   assign hit_ctrl   = waddr == ADDR_W'(REG_BASE + CTRL_OFF);
   assign hit_status = waddr == ADDR_W'(REG_BASE + STATUS_OFF);
   assign hit_pixcnt = waddr == ADDR_W'(REG_BASE + PIXCNT_OFF);
   assign mapped     = hit_data | hit_fb | hit_ctrl | hit_status | hit_pixcnt;
   assign writable   = hit_data | hit_ctrl;

   assign ld      = mem_req & ~mem_we;
   assign st      = mem_req & mem_we;
   assign ctrl_wr = st & hit_ctrl;

   // The capture engine sees the CTRL value being written this edge so that
   // disabling or clearing takes effect on the write edge itself.
   assign cap_en_in = ctrl_wr ? mem_wdata[CTRL_CAP_EN] : cap_en;
   assign clear     = ctrl_wr & mem_wdata[CTRL_CLEAR];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cap_en <= 1'b0;
      else        cap_en <= cap_en_in;
   end

   always_ff @(posedge clk) begin
      if (st && hit_data) dram[waddr[DA_W+1:2]] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (fb_we) fbuf[fb_waddr] <= fb_wdata;
   end

   // Combinational read of the pre-edge array contents gives read-before-write
   // against a camera write landing on the same edge.
   always_comb begin
      rd_mux = 32'd0;
      if (hit_data)        rd_mux = dram[waddr[DA_W+1:2]];
      else if (hit_fb)     rd_mux = fbuf[fb_off[FA_W+1:2]];
      else if (hit_ctrl)   rd_mux = {31'd0, cap_en};
      else if (hit_status) rd_mux = {29'd0, resync, busy, frame_done};
      else if (hit_pixcnt) rd_mux = {16'd0, pixcnt};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_rdata  <= 32'd0;
         mem_rvalid <= 1'b0;
         mem_err    <= 1'b0;
      end else begin
         mem_rvalid <= ld;
         mem_err    <= (ld & ~mapped) | (st & ~writable);
         if (ld) mem_rdata <= rd_mux;
      end
   end

   camera_capture #(
      .FB_WORDS (FB_WORDS),
      .FA_W     (FA_W)
   ) u_capture (
      .clk         (clk),
      .reset       (reset),
      .cap_en      (cap_en_in),
      .clear       (clear),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .frame_start (frame_start),
      .fb_we       (fb_we),
      .fb_waddr    (fb_waddr),
      .fb_wdata    (fb_wdata),
      .frame_done  (frame_done),
      .resync      (resync),
      .busy        (busy),
      .pixcnt      (pixcnt)
   );

   assign frame_irq = frame_done;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed stimulus, behavioural model, per-cycle compare.
// Latency: model predicts load responses one cycle after the request.
// Backpressure: n/a.
module tb_data_mem_responder;

   localparam int FB_WORDS = 4800;
   localparam int DATA_WORDS = 1024;
   localparam logic [31:0] A_FB     = 32'h0001_0000;
   localparam logic [31:0] A_CTRL   = 32'h0002_0000;
   localparam logic [31:0] A_STATUS = 32'h0002_0004;
   localparam logic [31:0] A_PIXCNT = 32'h0002_0008;

   logic        clk, reset;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rvalid, mem_err;
   logic        pix_valid, frame_start, frame_irq;
   logic [7:0]  pix_data;

   data_mem_responder dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_rvalid  (mem_rvalid),
      .mem_err     (mem_err),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .frame_start (frame_start),
      .frame_irq   (frame_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Model: mode 0 idle, 1 waiting for start, 2 capturing, 3 frame complete
   logic [31:0] dm [int];
   logic [31:0] fbm [FB_WORDS];
   logic [7:0]  part [$];
   int          m_mode = 0;
   int          m_words = 0;
   bit          m_en = 0, m_done = 0, m_resync = 0;

   bit          chk_en = 0;
   bit          exp_rvalid = 0, exp_err = 0, exp_irq = 0;
   logic [31:0] exp_rdata = 32'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rvalid", {31'd0, mem_rvalid}, {31'd0, exp_rvalid});
         chk("err", {31'd0, mem_err}, {31'd0, exp_err});
         chk("rdata", mem_rdata, exp_rdata);
         chk("frame_irq", {31'd0, frame_irq}, {31'd0, exp_irq});
      end
   end

   task automatic step(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input bit pv, input logic [7:0] pd, input bit fs);
      logic [31:0] a, n_rd;
      bit n_rv, n_er, new_en, clr, busy;
      mem_req = req; mem_we = we; mem_addr = addr; mem_wdata = wd;
      pix_valid = pv; pix_data = pd; frame_start = fs;
      a = addr & ~32'h3;
      n_rv = 0; n_er = 0; n_rd = exp_rdata; new_en = m_en; clr = 0;
      busy = (m_mode == 1) || (m_mode == 2);
      if (req && !we) begin
         n_rv = 1;
         if (a < 4 * DATA_WORDS)                          n_rd = dm[int'(a >> 2)];
         else if (a >= A_FB && a < A_FB + 4 * FB_WORDS)   n_rd = fbm[int'((a - A_FB) >> 2)];
         else if (a == A_CTRL)                            n_rd = {31'd0, m_en};
         else if (a == A_STATUS)                          n_rd = {29'd0, m_resync, busy, m_done};
         else if (a == A_PIXCNT)                          n_rd = 32'(m_words);
         else begin n_rd = 32'd0; n_er = 1; end
      end else if (req && we) begin
         if (a < 4 * DATA_WORDS)  dm[int'(a >> 2)] = wd;
         else if (a == A_CTRL)    begin new_en = wd[0]; clr = wd[1]; end
         else                     n_er = 1;
      end
      // camera behaviour for this edge
      if (clr) begin m_done = 0; m_resync = 0; end
      if (!new_en) begin
         m_mode = 0;
         part.delete();
      end else if (clr && m_mode == 3) begin
         m_mode = 1;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (fs) begin m_mode = 2; m_words = 0; part.delete(); end
      end else if (m_mode == 2) begin
         if (fs) begin m_words = 0; part.delete(); m_resync = 1; end
         if (pv) begin
            part.push_back(pd);
            if (part.size() == 4) begin
               fbm[m_words] = {part[3], part[2], part[1], part[0]};
               m_words++;
               part.delete();
               if (m_words == FB_WORDS) begin m_mode = 3; m_done = 1; end
            end
         end
      end
      m_en = new_en;
      @(posedge clk);
      #1;
      exp_rvalid = n_rv; exp_err = n_er; exp_rdata = n_rd; exp_irq = m_done;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d); step(1, 1, a, d, 0, 8'h00, 0); endtask
   task automatic ld(input logic [31:0] a);                        step(1, 0, a, 32'd0, 0, 8'h00, 0); endtask
   task automatic idle();                                          step(0, 0, 32'd0, 32'd0, 0, 8'h00, 0); endtask
   task automatic px(input logic [7:0] d);                         step(0, 0, 32'd0, 32'd0, 1, d, 0); endtask
   task automatic sof();                                           step(0, 0, 32'd0, 32'd0, 0, 8'h00, 1); endtask

   task automatic ldchk(input string nm, input logic [31:0] a, input logic [31:0] lit);
      ld(a);
      @(negedge clk);
      chk({nm, "_rvalid"}, {31'd0, mem_rvalid}, 32'd1);
      chk(nm, mem_rdata, lit);
   endtask

   initial begin
      reset = 1'b0;
      mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
      pix_valid = 0; pix_data = 0; frame_start = 0;
      repeat (2) @(negedge clk);
      chk("reset_rvalid", {31'd0, mem_rvalid}, 32'd0);
      chk("reset_err", {31'd0, mem_err}, 32'd0);
      chk("reset_rdata", mem_rdata, 32'd0);
      chk("reset_irq", {31'd0, frame_irq}, 32'd0);
      reset = 1'b1;
      chk_en = 1;
      ldchk("reset_status", A_STATUS, 32'h0);
      ldchk("reset_pixcnt", A_PIXCNT, 32'h0);

      // 1: data RAM store/load, back-to-back loads, rdata hold
      st(32'h0000_0010, 32'hDEAD_BEEF);
      st(32'h0000_0017, 32'h0BAD_F00D);          // low address bits ignored -> word 0x14
      ldchk("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
      chk("ram_10_err", {31'd0, mem_err}, 32'd0);
      ld(32'h0000_0014);
      ld(32'h0000_0010);
      idle();
      idle();

      // 2: first packed word
      st(A_CTRL, 32'h1);
      idle();
      sof();
      px(8'h11); px(8'h22); px(8'h33); px(8'h44);
      ldchk("fb0_t2", A_FB, 32'h4433_2211);
      ldchk("pixcnt_t2", A_PIXCNT, 32'd1);
      ldchk("status_t2", A_STATUS, 32'h2);
      ldchk("ctrl_t2", A_CTRL, 32'h1);

      // 3: full frame, extra pixels ignored, clear back to waiting
      st(A_CTRL, 32'h0);
      st(A_CTRL, 32'h1);
      sof();
      for (int i = 0; i < 4 * FB_WORDS; i++) px(8'(i * 7 + 3));
      for (int i = 0; i < 8; i++) px(8'h55);
      ldchk("status_t3", A_STATUS, 32'h1);
      chk("irq_t3", {31'd0, frame_irq}, 32'd1);
      ldchk("pixcnt_t3", A_PIXCNT, 32'd4800);
      ldchk("fb_last_t3", A_FB + 32'h4AFC, 32'hFCF5_EEE7);
      ldchk("fb0_t3", A_FB, 32'h1811_0A03);
      st(A_CTRL, 32'h3);
      ldchk("status_clr_t3", A_STATUS, 32'h2);

      // 4: resync, coincident start+pixel, read-before-write on fb
      sof();
      for (int i = 0; i < 10; i++) px(8'(8'hC0 + i));
      sof();
      px(8'hA0); px(8'hA1); px(8'hA2); px(8'hA3);
      ldchk("status_t4", A_STATUS, 32'h6);
      ldchk("pixcnt_t4", A_PIXCNT, 32'd1);
      ldchk("fb0_t4", A_FB, 32'hA3A2_A1A0);
      step(0, 0, 32'd0, 32'd0, 1, 8'hB0, 1);
      px(8'hB1); px(8'hB2);
      step(1, 0, A_FB, 32'd0, 1, 8'hB3, 0);
      @(negedge clk);
      chk("fb0_rbw", mem_rdata, 32'hA3A2_A1A0);
      ldchk("fb0_sof_pix", A_FB, 32'hB3B2_B1B0);
      ldchk("pixcnt_sof_pix", A_PIXCNT, 32'd1);

      // 5: errors
      ld(32'h0003_0000);
      @(negedge clk);
      chk("unmapped_ld_err", {31'd0, mem_err}, 32'd1);
      chk("unmapped_ld_rdata", mem_rdata, 32'd0);
      chk("unmapped_ld_rvalid", {31'd0, mem_rvalid}, 32'd1);
      st(A_FB, 32'h1234_5678);
      @(negedge clk);
      chk("fb_st_err", {31'd0, mem_err}, 32'd1);
      chk("fb_st_rvalid", {31'd0, mem_rvalid}, 32'd0);
      ldchk("fb0_after_st", A_FB, 32'hB3B2_B1B0);
      ld(32'h0000_1000);                           // one past data RAM
      ld(A_FB + 32'h4B00);                         // one past frame buffer
      ld(A_FB + 32'h4AFC);                         // last frame-buffer word
      st(32'h0004_0000, 32'h1);                    // unmapped store
      idle();

      // 6: async reset during capture, with frame_done still set
      st(A_CTRL, 32'h0);
      st(A_CTRL, 32'h1);
      sof();
      for (int i = 0; i < 4 * FB_WORDS; i++) px(8'(i * 13 + 5));
      st(A_CTRL, 32'h0);
      ldchk("status_done_kept", A_STATUS, 32'h5);
      st(A_CTRL, 32'h1);
      sof();
      px(8'h01); px(8'h02); px(8'h03);
      ld(A_STATUS);                                // rvalid high going into the reset
      chk_en = 0;
      #1 reset = 1'b0;
      #1;
      chk("arst_rvalid", {31'd0, mem_rvalid}, 32'd0);
      chk("arst_err", {31'd0, mem_err}, 32'd0);
      chk("arst_rdata", mem_rdata, 32'd0);
      chk("arst_irq", {31'd0, frame_irq}, 32'd0);
      m_en = 0; m_mode = 0; m_done = 0; m_resync = 0; m_words = 0; part.delete();
      exp_rvalid = 0; exp_err = 0; exp_rdata = 32'd0; exp_irq = 0;
      mem_req = 0; pix_valid = 0; frame_start = 0;
      @(negedge clk);
      reset = 1'b1;
      chk_en = 1;
      sof();
      for (int i = 0; i < 8; i++) px(8'hEE);
      ldchk("status_post_rst", A_STATUS, 32'h0);
      ldchk("pixcnt_post_rst", A_PIXCNT, 32'd0);
      ldchk("ctrl_post_rst", A_CTRL, 32'd0);
      ldchk("ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
      ld(A_FB);
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the pipelined ARM core's data interface. It serves core loads and stores to a word-addressed data RAM and a camera frame buffer. It also provides a small memory-mapped control/status register block. A camera capture engine packs 8-bit pixels into 32-bit words and writes them into the frame buffer, independently of core accesses.

Parameters:
DATA_WORDS, 1024, depth of data RAM in 32-bit words
FB_WORDS, 4800, depth of frame buffer in words (160x120 8-bit pixels / 4)
ADDR_W, 32, core address width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
mem_req  in  1  core access strobe, one access per cycle
mem_we  in  1  1 = store, 0 = load (qualified by mem_req)
mem_addr  in  ADDR_W  byte address from core ALU result; bits[1:0] ignored
mem_wdata  in  32  store data
mem_rdata  out  32  load data, valid with mem_rvalid
mem_rvalid  out  1  load response pulse
mem_err  out  1  error pulse (unmapped access, or store to read-only region)
pix_valid  in  1  camera pixel strobe
pix_data  in  8  camera pixel
frame_start  in  1  camera start-of-frame pulse
frame_irq  out  1  level; equals STATUS.frame_done

Behaviour:
- Reset (reset=0, async), applied immediately:
  - mem_rdata=0, mem_rvalid=0, mem_err=0.
  - CTRL=0, STATUS=0, PIXCNT=0, capture FSM=IDLE, packer lane=0.
  - RAM contents are not reset.
- Memory map (byte addresses):
  - 0x0000_0000..4*DATA_WORDS-1: data RAM, read/write.
  - 0x0001_0000..+4*FB_WORDS-1: frame buffer, core read-only.
  - 0x0002_0000 CTRL: bit0 cap_en (R/W); bit1 clear (write-1 pulse, reads 0).
  - 0x0002_0004 STATUS (RO): bit0 frame_done, bit1 busy (WAIT_SOF or CAPTURE), bit2 resync.
  - 0x0002_0008 PIXCNT (RO): [15:0] words written in the current frame.
  - Everything else is unmapped.
- Stores: take effect at the rising edge where mem_req=1 and mem_we=1. No response pulse.
- Loads: mem_rvalid=1 exactly one cycle after mem_req=1 with mem_we=0; mem_rdata holds the registered read data.
  - Back-to-back loads give back-to-back rvalid.
  - mem_rdata holds its last value when rvalid=0.
- Errors:
  - Unmapped load: rvalid=1, rdata=0, err=1, all in the same cycle (1-cycle latency).
  - Unmapped store, or store to frame buffer: err=1 the next cycle, no state change.
- Capture FSM states: IDLE, WAIT_SOF, CAPTURE, DONE.
  - IDLE -> WAIT_SOF when cap_en=1.
  - WAIT_SOF -> CAPTURE on frame_start; idx=0, lane=0, PIXCNT=0.
  - CAPTURE, each pix_valid: pixel goes into lane (little-endian, first pixel at bits[7:0]), then lane++.
  - On lane 3: the packed word is written to fb[idx] on the same edge; idx++, PIXCNT++.
  - CAPTURE -> DONE when idx reaches FB_WORDS; frame_done=1 on that edge.
  - frame_start during CAPTURE: restart at idx=0, lane=0, PIXCNT=0, set resync. A frame_start coinciding with pix_valid restarts first; that pixel becomes pixel 0.
  - DONE: pixels and frame_start are ignored.
  - CTRL clear in any state clears frame_done and resync. In DONE it then moves to WAIT_SOF if cap_en=1, else IDLE.
  - cap_en=0 written in any state -> IDLE next cycle. Any partial word is discarded; frame_done is kept.
- Simultaneous core load and camera write to the same fb word: the core gets the old contents (read-before-write).
- frame_irq mirrors frame_done combinationally from the register.

Decomposition:
- Package cam_mem_pkg: region base addresses, region sizes, register offsets, STATUS/CTRL bit indices, and capture_state_t enum {IDLE, WAIT_SOF, CAPTURE, DONE}.
- Sub-module camera_capture: FSM, pixel packer, idx/PIXCNT counters.
  - Outputs: fb write enable/address/data, frame_done, resync, busy.
- The top keeps address decode, the two RAM arrays, the CTRL register, and response logic.

Test Plan:
1. Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> next cycle rvalid=1, rdata=0xDEADBEEF, err=0.
2. CTRL=0x1, frame_start, pixels 0x11,0x22,0x33,0x44 -> load 0x0001_0000 returns 0x44332211; PIXCNT=1; STATUS=0x2.
3. Full 19200-pixel frame plus 8 extra pixels -> STATUS=0x1, frame_irq=1, PIXCNT=4800, last word correct; extra pixels ignored. CTRL=0x3 -> STATUS=0x2 (WAIT_SOF).
4. frame_start after 10 pixels, then 4 pixels 0xA0..0xA3 -> STATUS.resync=1, PIXCNT=1, fb[0]=0xA3A2A1A0.
5. Load 0x0003_0000 -> rvalid=1, rdata=0, err=1. Store 0x12345678 to 0x0001_0000 -> err=1, fb[0] unchanged.
6. Assert reset mid-CAPTURE asynchronously (between clock edges) -> STATUS=0, rvalid=0, frame_irq=0 immediately. After release, FSM in IDLE; pixels ignored until cap_en=1.
